// File: rtl/ddr_burst_arbiter_pkg.sv
// Shared types for the DDR burst arbiter: FSM state encoding, grant direction
// and the bytes-per-beat helper. Package name: ddr_arb_pkg.
package ddr_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4
    } arb_state_e;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    function automatic int BYTES_PER_BEAT(input int axi_width);
        return axi_width / 8;
    endfunction

endpackage

// File: rtl/ddr_burst_arbiter_if.sv
// Request, window configuration and burst descriptor signals between the FIFO
// detectors, the arbiter and the AXI write/read masters.
interface ddr_burst_arbiter_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int LEN_WIDTH  = 8
);
    logic                  wr_req;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] wr_beg_addr;
    logic [ADDR_WIDTH-1:0] wr_end_addr;
    logic [ADDR_WIDTH-1:0] rd_beg_addr;
    logic [ADDR_WIDTH-1:0] rd_end_addr;
    logic [LEN_WIDTH-1:0]  wr_burst_len;
    logic [LEN_WIDTH-1:0]  rd_burst_len;
    logic                  wr_addr_clr;
    logic                  rd_addr_clr;
    logic                  wr_start;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [LEN_WIDTH-1:0]  wr_len;
    logic                  wr_done;
    logic                  rd_start;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [LEN_WIDTH-1:0]  rd_len;
    logic                  rd_done;
    logic                  busy;

    // Arbiter view
    modport master (
        input  wr_req, rd_req, wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr,
               wr_burst_len, rd_burst_len, wr_addr_clr, rd_addr_clr, wr_done, rd_done,
        output wr_start, wr_addr, wr_len, rd_start, rd_addr, rd_len, busy
    );

    // Surrounding DDR interface view
    modport slave (
        output wr_req, rd_req, wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr,
               wr_burst_len, rd_burst_len, wr_addr_clr, rd_addr_clr, wr_done, rd_done,
        input  wr_start, wr_addr, wr_len, rd_start, rd_addr, rd_len, busy
    );

endinterface

// File: rtl/ddr_burst_arbiter_addr_gen.sv
// burst_addr_gen: per-direction wrap-around burst pointer inside an inclusive
// [beg_addr, end_addr] window, with a fresh flag that forces the next issue to beg_addr.
module burst_addr_gen
    import ddr_arb_pkg::*;
#(
    parameter int AXI_WIDTH  = 64,
    parameter int ADDR_WIDTH = 30,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] beg_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  addr_clr,
    input  logic                  issue,
    input  logic                  done,
    output logic [ADDR_WIDTH-1:0] cur_addr
);
    typedef logic [ADDR_WIDTH:0] wide_t;

    localparam int BPB = BYTES_PER_BEAT(AXI_WIDTH);

    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] next_ptr;
    logic                  fresh;
    wide_t                 burst_bytes;
    wide_t                 step_addr;
    wide_t                 last_byte;

    // One extra bit so ptr + 2*bytes near the top of the address space cannot wrap.
    assign burst_bytes = (wide_t'(burst_len) + wide_t'(1)) * wide_t'(BPB);
    assign step_addr   = wide_t'(ptr) + burst_bytes;
    assign last_byte   = step_addr + burst_bytes - wide_t'(1);
    assign next_ptr    = (last_byte > wide_t'(end_addr)) ? beg_addr : step_addr[ADDR_WIDTH-1:0];
    assign cur_addr    = fresh ? beg_addr : ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            fresh <= 1'b1;
        end else if (addr_clr) begin
            // Clear wins over a coincident done; the burst in flight keeps its latched address.
            ptr   <= beg_addr;
            fresh <= 1'b1;
        end else if (issue) begin
            ptr   <= cur_addr;
            fresh <= 1'b0;
        end else if (done) begin
            ptr   <= next_ptr;
        end
    end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Schedules one burst at a time on the shared MIG AXI port between write and read.
// Tie-break: round-robin by default; `define ARB_RD_PRIORITY_EN makes reads always win.
module ddr_burst_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int AXI_WIDTH  = 64,
    parameter int ADDR_WIDTH = 30,
    parameter int LEN_WIDTH  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    ddr_burst_arbiter_if.master bus
);
    localparam logic [2:0] IDLE     = ST_IDLE;
    localparam logic [2:0] WR_ISSUE = ST_WR_ISSUE;
    localparam logic [2:0] WR_WAIT  = ST_WR_WAIT;
    localparam logic [2:0] RD_ISSUE = ST_RD_ISSUE;
    localparam logic [2:0] RD_WAIT  = ST_RD_WAIT;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic                  grant_wr;
    logic                  grant_rd;
    logic [ADDR_WIDTH-1:0] wr_cur;
    logic [ADDR_WIDTH-1:0] rd_cur;
    logic                  wr_done_ok;
    logic                  rd_done_ok;

    // Done pulses outside the matching WAIT state are ignored entirely.
    assign wr_done_ok = bus.wr_done && (state == WR_WAIT);
    assign rd_done_ok = bus.rd_done && (state == RD_WAIT);

`ifdef ARB_RD_PRIORITY_EN
    always_comb begin
        grant_rd = bus.rd_req;
        grant_wr = bus.wr_req && !bus.rd_req;
    end
`else
    grant_e last_grant;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (bus.wr_req && bus.rd_req) begin
            grant_rd = (last_grant == GRANT_WR);
            grant_wr = (last_grant == GRANT_RD);
        end else begin
            grant_wr = bus.wr_req;
            grant_rd = bus.rd_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_WR;
        end else if (state == IDLE) begin
            if (grant_wr)      last_grant <= GRANT_WR;
            else if (grant_rd) last_grant <= GRANT_RD;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_wr)      state_nxt = WR_ISSUE;
                else if (grant_rd) state_nxt = RD_ISSUE;
            end
            WR_ISSUE: state_nxt = WR_WAIT;
            WR_WAIT:  if (bus.wr_done) state_nxt = IDLE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  if (bus.rd_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.wr_start <= 1'b0;
            bus.rd_start <= 1'b0;
            bus.busy     <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_len   <= '0;
            bus.rd_addr  <= '0;
            bus.rd_len   <= '0;
        end else begin
            state        <= state_nxt;
            bus.wr_start <= (state == WR_ISSUE);
            bus.rd_start <= (state == RD_ISSUE);
            bus.busy     <= (state_nxt == WR_WAIT) || (state_nxt == RD_WAIT);
            // Descriptor is captured leaving ISSUE and held until the next issue.
            if (state == WR_ISSUE) begin
                bus.wr_addr <= wr_cur;
                bus.wr_len  <= bus.wr_burst_len;
            end
            if (state == RD_ISSUE) begin
                bus.rd_addr <= rd_cur;
                bus.rd_len  <= bus.rd_burst_len;
            end
        end
    end

    burst_addr_gen #(
        .AXI_WIDTH (AXI_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_wr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .beg_addr (bus.wr_beg_addr),
        .end_addr (bus.wr_end_addr),
        .burst_len(bus.wr_burst_len),
        .addr_clr (bus.wr_addr_clr),
        .issue    (state == WR_ISSUE),
        .done     (wr_done_ok),
        .cur_addr (wr_cur)
    );

    burst_addr_gen #(
        .AXI_WIDTH (AXI_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_rd_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .beg_addr (bus.rd_beg_addr),
        .end_addr (bus.rd_end_addr),
        .burst_len(bus.rd_burst_len),
        .addr_clr (bus.rd_addr_clr),
        .issue    (state == RD_ISSUE),
        .done     (rd_done_ok),
        .cur_addr (rd_cur)
    );

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter: grant table plus wrap, clear, reset and
// spurious-done sequences. Expectations follow ARB_RD_PRIORITY_EN when defined.
module tb_ddr_burst_arbiter;
    localparam int AW = 30;
    localparam int LW = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    ddr_burst_arbiter_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    ddr_burst_arbiter #(.AXI_WIDTH(64), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic        exp_rd;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns the granted burst and the
    // number of cycles until its start pulse was sampled.
    task automatic launch(input logic w, input logic r, output logic got_rd,
                          output logic [31:0] got_addr, output logic [31:0] got_len,
                          output int lat);
        bus.wr_req = w;
        bus.rd_req = r;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(bus.wr_start || bus.rd_start) && lat < 16);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        got_rd   = bus.rd_start;
        got_addr = got_rd ? 32'(bus.rd_addr) : 32'(bus.wr_addr);
        got_len  = got_rd ? 32'(bus.rd_len) : 32'(bus.wr_len);
    endtask

    task automatic launch_chk(input string tag, input logic w, input logic r,
                              input logic exp_rd, input logic [31:0] exp_addr,
                              input logic [31:0] exp_len);
        logic        got_rd;
        logic [31:0] got_addr;
        logic [31:0] got_len;
        int          lat;
        launch(w, r, got_rd, got_addr, got_len, lat);
        check({tag, " latency"}, 32'(lat), 32'd2);
        check({tag, " dir"}, 32'(got_rd), 32'(exp_rd));
        check({tag, " addr"}, got_addr, exp_addr);
        check({tag, " len"}, got_len, exp_len);
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
    endtask

    // Called at the negedge where start was seen; finishes the burst with done.
    task automatic complete(input string tag, input logic is_rd, input logic [31:0] exp_addr,
                            input logic clr_mid, input logic clr_at_done);
        @(negedge clk);
        check({tag, " start pulse"}, 32'(is_rd ? bus.rd_start : bus.wr_start), 32'd0);
        if (clr_mid) begin
            if (is_rd) bus.rd_addr_clr = 1'b1; else bus.wr_addr_clr = 1'b1;
        end
        @(negedge clk);
        bus.rd_addr_clr = 1'b0;
        bus.wr_addr_clr = 1'b0;
        @(negedge clk);
        check({tag, " held addr"}, is_rd ? 32'(bus.rd_addr) : 32'(bus.wr_addr), exp_addr);
        if (is_rd) bus.rd_done = 1'b1; else bus.wr_done = 1'b1;
        if (clr_at_done) begin
            if (is_rd) bus.rd_addr_clr = 1'b1; else bus.wr_addr_clr = 1'b1;
        end
        @(negedge clk);
        bus.rd_done     = 1'b0;
        bus.wr_done     = 1'b0;
        bus.rd_addr_clr = 1'b0;
        bus.wr_addr_clr = 1'b0;
        check({tag, " busy fall"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic pulse_clr(input logic is_rd);
        if (is_rd) bus.rd_addr_clr = 1'b1; else bus.wr_addr_clr = 1'b1;
        @(negedge clk);
        bus.rd_addr_clr = 1'b0;
        bus.wr_addr_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
`ifdef ARB_RD_PRIORITY_EN
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'd2048};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'd2176};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'd2304};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'd256};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'd2432};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'd2048};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'd512};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 32'd0};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 32'd2176};
`else
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'd2048};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'd256};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'd2176};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'd512};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'd2304};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'd2432};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 32'd256};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 32'd2048};
`endif

        rst_n            = 1'b0;
        bus.wr_req       = 1'b0;
        bus.rd_req       = 1'b0;
        bus.wr_done      = 1'b0;
        bus.rd_done      = 1'b0;
        bus.wr_addr_clr  = 1'b0;
        bus.rd_addr_clr  = 1'b0;
        bus.wr_beg_addr  = 30'd0;
        bus.wr_end_addr  = 30'd1000;
        bus.wr_burst_len = 8'd31;
        bus.rd_beg_addr  = 30'd2048;
        bus.rd_end_addr  = 30'd2559;
        bus.rd_burst_len = 8'd15;
        repeat (2) @(negedge clk);
        check("reset wr_start", 32'(bus.wr_start), 32'd0);
        check("reset rd_start", 32'(bus.rd_start), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset wr_addr", 32'(bus.wr_addr), 32'd0);
        check("reset rd_addr", 32'(bus.rd_addr), 32'd0);
        check("reset wr_len", 32'(bus.wr_len), 32'd0);
        check("reset rd_len", 32'(bus.rd_len), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Grant table: odd write window 0..1000 (256 B bursts), read window 2048..2559 (128 B).
        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            launch_chk(tag, vecs[i].wr, vecs[i].rd, vecs[i].exp_rd, vecs[i].exp_addr,
                       vecs[i].exp_rd ? 32'd15 : 32'd31);
            complete(tag, vecs[i].exp_rd, vecs[i].exp_addr, 1'b0, 1'b0);
        end

        // Write-only wrap at the top of the 4915199 window: eight bursts then back to begin.
        bus.wr_beg_addr = 30'd4913152;
        bus.wr_end_addr = 30'd4915199;
        pulse_clr(1'b0);
        for (int i = 0; i < 9; i++) begin
            logic [31:0] exp_a;
            exp_a = (i < 8) ? 32'd4913152 + 32'(i) * 32'd256 : 32'd4913152;
            launch_chk($sformatf("wrap%0d", i), 1'b1, 1'b0, 1'b0, exp_a, 32'd31);
            complete($sformatf("wrap%0d", i), 1'b0, exp_a, 1'b0, 1'b0);
        end

        // Read clear during WAIT and coincident with done.
        bus.rd_beg_addr  = 30'd0;
        bus.rd_end_addr  = 30'd4095;
        bus.rd_burst_len = 8'd31;
        pulse_clr(1'b1);
        for (int i = 0; i < 4; i++) begin
            launch_chk($sformatf("rdseq%0d", i), 1'b0, 1'b1, 1'b1, 32'(i) * 32'd256, 32'd31);
            complete($sformatf("rdseq%0d", i), 1'b1, 32'(i) * 32'd256, 1'b0, 1'b0);
        end
        launch_chk("clrmid", 1'b0, 1'b1, 1'b1, 32'd1024, 32'd31);
        complete("clrmid", 1'b1, 32'd1024, 1'b1, 1'b0);
        launch_chk("after clrmid", 1'b0, 1'b1, 1'b1, 32'd0, 32'd31);
        complete("after clrmid", 1'b1, 32'd0, 1'b0, 1'b0);
        launch_chk("clrdone", 1'b0, 1'b1, 1'b1, 32'd256, 32'd31);
        complete("clrdone", 1'b1, 32'd256, 1'b0, 1'b1);
        launch_chk("after clrdone", 1'b0, 1'b1, 1'b1, 32'd0, 32'd31);
        complete("after clrdone", 1'b1, 32'd0, 1'b0, 1'b0);

        // Spurious rd_done in IDLE, then during WR_WAIT.
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_done = 1'b0;
        repeat (3) @(negedge clk);
        check("spur idle busy", 32'(bus.busy), 32'd0);
        check("spur idle rd_start", 32'(bus.rd_start), 32'd0);
        launch_chk("spur wr", 1'b1, 1'b0, 1'b0, 32'd4913408, 32'd31);
        @(negedge clk);
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_done = 1'b0;
        @(negedge clk);
        check("spur wait busy", 32'(bus.busy), 32'd1);
        bus.wr_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
        check("spur wait busy fall", 32'(bus.busy), 32'd0);
        launch_chk("spur rd ptr", 1'b0, 1'b1, 1'b1, 32'd256, 32'd31);
        complete("spur rd ptr", 1'b1, 32'd256, 1'b0, 1'b0);

        // Asynchronous reset while the write burst is outstanding.
        bus.wr_beg_addr = 30'd512;
        bus.wr_end_addr = 30'd8191;
        pulse_clr(1'b0);
        launch_chk("rst pre", 1'b1, 1'b0, 1'b0, 32'd512, 32'd31);
        complete("rst pre", 1'b0, 32'd512, 1'b0, 1'b0);
        launch_chk("rst burst", 1'b1, 1'b0, 1'b0, 32'd768, 32'd31);
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst wr_start", 32'(bus.wr_start), 32'd0);
        check("rst wr_addr", 32'(bus.wr_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch_chk("post rst", 1'b1, 1'b0, 1'b0, 32'd512, 32'd31);
        complete("post rst", 1'b0, 32'd512, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ddr_burst_arbiter.md
# ddr_burst_arbiter

Schedules burst transfers between the user-side write FIFO path and read FIFO path and the single shared AXI port of the DDR3 MIG. Each transfer is one burst. The block decides which direction owns the AXI port next, generates wrap-around burst addresses inside each direction's configured window, and hands one burst at a time to the AXI write master or AXI read master. It sits inside the DDR interface on the MIG user clock, between the FIFO fill/room detectors and the AXI masters.

## Interface
- `AXI_WIDTH`, 64, AXI data width in bits; bytes per beat `AXI_WIDTH/8`.
- `ADDR_WIDTH`, 30, byte address width.
- `LEN_WIDTH`, 8, burst length field width (AXI `axlen` semantics, beats = len+1).
- `clk` in 1: MIG `ui_clk`, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_req` in 1: write FIFO holds ≥ one burst.
- `rd_req` in 1: read FIFO has room for one burst and `rd_mem_enable` is high (qualified upstream).
- `wr_beg_addr`, `wr_end_addr` in ADDR_WIDTH: write window, inclusive byte addresses, quasi-static.
- `rd_beg_addr`, `rd_end_addr` in ADDR_WIDTH: read window, inclusive byte addresses, quasi-static.
- `wr_burst_len`, `rd_burst_len` in LEN_WIDTH: quasi-static.
- `wr_addr_clr`, `rd_addr_clr` in 1: synchronous pointer restart to the window begin.
- `wr_start` out 1: one-cycle pulse that launches a write burst.
- `wr_addr` out ADDR_WIDTH and `wr_len` out LEN_WIDTH: write burst descriptor.
- `wr_done` in 1: one-cycle pulse from the write master after BRESP.
- `rd_start` out 1, `rd_addr` out ADDR_WIDTH, `rd_len` out LEN_WIDTH: same meaning for reads.
- `rd_done` in 1: one-cycle pulse from the read master after the last RDATA beat.
- `busy` out 1: a burst is outstanding.

## Operation
- FSM states and transitions:
  - IDLE → WR_ISSUE or RD_ISSUE on grant.
  - WR_ISSUE → WR_WAIT after one cycle. RD_ISSUE → RD_WAIT after one cycle.
  - WR_WAIT → IDLE on `wr_done`. RD_WAIT → IDLE on `rd_done`.
- Grant is evaluated only in IDLE.
  - If exactly one request is high, that direction is granted.
  - If both are high, round-robin: the direction not served last is granted. `last_grant` resets to WR, so the first tie after reset goes to RD.
- Burst bytes = (len+1)·AXI_WIDTH/8. Compute at ADDR_WIDTH+1 bits so the sum cannot overflow.
- Pointer update happens on the done pulse: next = ptr + bytes. If next + bytes − 1 > end_addr, next = beg_addr. A burst never crosses end_addr.
- First-use rule: after reset or after `*_addr_clr`, a per-direction `fresh` flag is set. The next issue uses `beg_addr` and then clears `fresh`.
- `*_addr_clr` while that direction's burst is outstanding:
  - The current burst completes with its latched address.
  - The pointer restarts at begin.
  - Clear has priority over a coincident done.
- The descriptor (`*_addr`, `*_len`) is latched in the ISSUE state and held stable until the matching done pulse.
- A done pulse seen in a state that does not expect it is ignored. No state change results.
- Requests deasserting during WAIT have no effect; the burst is not aborted.

## Timing
- Reset values: `wr_start`=0, `rd_start`=0, `busy`=0, all addresses 0, all lengths 0, state IDLE, both `fresh` flags set.
- All outputs are registered.
- Request-to-start latency: request high in IDLE at edge N; `*_start` is high for the cycle following N+1.
- Done-to-next-start: done at edge M; IDLE at M+1; next `*_start` at M+2. Minimum 2 idle cycles between bursts.
- `busy` rises together with `*_start` and falls the cycle after done.
- Asynchronous reset mid-burst returns the block to IDLE immediately. The masters are reset by the same `ui_rst`.

## Configuration
- `ARB_RD_PRIORITY_EN`:
  - Defined: on a tie, read always wins (fixed priority, protecting HDMI scan-out against underrun). `last_grant` is unused.
  - Undefined: round-robin as described in Operation.

## Structure
- Package `ddr_arb_pkg` holds:
  - the FSM state enum (IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT);
  - the grant direction enum;
  - the `BYTES_PER_BEAT` constant function.
- Sub-module `burst_addr_gen` contains pointer, fresh flag, clear and wrap logic. It is instantiated twice, once for write and once for read.

## Test plan
- Write only: AXI_WIDTH=64, len=31, window 0..4915199, `wr_req` held high, `wr_done` 5 cycles after each start → `wr_addr` sequence 0, 256, 512, …, 4914944, then 0. Wrap occurs after exactly 19200 bursts.
- Both requests held high → grants alternate RD, WR, RD, WR, starting with RD. With `ARB_RD_PRIORITY_EN` defined → RD only.
- Odd window 0..1000, len=31 → addresses 0, 256, 512, then 0. The burst at 768 would cross end_addr and is skipped.
- `rd_addr_clr` pulsed during RD_WAIT at address 1024 → the burst completes with `rd_addr`=1024; the next read burst is at `rd_beg_addr`. Also pulse clr in the same cycle as `rd_done` → the next read burst is still at begin.
- `rst_n` dropped during WR_WAIT → `busy`, `wr_start` and `wr_addr` are 0 immediately. After release, the first write burst is at `wr_beg_addr`.
- Spurious `rd_done` in IDLE and in WR_WAIT → no state change and no pointer change.
